// File: rtl/fifo_v3.sv
// ----------------------------------------------------------------------------
// fifo_v3
// Parameterisable synchronous FIFO with optional fall-through, flush and
// occupancy output. Any DEPTH is supported (non-powers-of-two included);
// DEPTH = 0 degenerates to a combinational bypass with no storage.
//
// Ports
//   clk_i       rising-edge clock
//   rst_ni      synchronous active-low reset (clears pointers, count, memory)
//   flush_i     synchronous clear of pointers and count
//   testmode_i  test-mode enable, no functional effect
//   full_o      FIFO holds DEPTH entries
//   empty_o     nothing to pop (fall-through push counts as non-empty)
//   usage_o     fill level, truncated to ADDR_DEPTH bits (0 when full for
//               power-of-two DEPTH; disambiguate with full_o)
//   data_i      write data
//   push_i      write request
//   data_o      head-of-queue data
//   pop_i       read request, consumes data_o
// ----------------------------------------------------------------------------
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    // Derived pointer / usage width; leave at its default.
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    // Test mode only exists as a hook for clock gating.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (DATA_WIDTH == 0) begin : g_chk_data_width
        $error("fifo_v3: DATA_WIDTH must be greater than zero");
    end

    if (ADDR_DEPTH != ((DEPTH > 1) ? $clog2(DEPTH) : 1)) begin : g_chk_addr_depth
        $error("fifo_v3: ADDR_DEPTH is derived from DEPTH and must not be overridden");
    end

    if (DEPTH == 0) begin : g_bypass
        // --------------------------------------------------------------------
        // Bypass: the consumer sees the producer directly, nothing is stored.
        // --------------------------------------------------------------------
        logic unused_bypass;
        assign unused_bypass = ^{clk_i, rst_ni, flush_i};

        assign data_o  = data_i;
        assign empty_o = ~push_i;
        assign full_o  = ~pop_i;
        assign usage_o = '0;

    end else begin : g_fifo
        // --------------------------------------------------------------------
        // Storage FIFO
        // --------------------------------------------------------------------
        localparam int unsigned           CNT_W    = ADDR_DEPTH + 1;
        localparam logic [ADDR_DEPTH-1:0] PTR_LAST = ADDR_DEPTH'(DEPTH - 1);
        localparam logic [ADDR_DEPTH-1:0] PTR_ONE  = ADDR_DEPTH'(1);
        localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
        localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

        logic [ADDR_DEPTH-1:0] read_ptr_q,   read_ptr_d;
        logic [ADDR_DEPTH-1:0] write_ptr_q,  write_ptr_d;
        logic [CNT_W-1:0]      status_cnt_q, status_cnt_d;
        dtype                  mem_q [DEPTH];
        dtype                  mem_d [DEPTH];

        logic cnt_zero;
        logic ft_push;
        logic pass_through;
        logic write_en;
        logic read_en;

        // Status decode from the registered count.
        assign cnt_zero = (status_cnt_q == '0);
        assign full_o   = (status_cnt_q == CNT_FULL);
        assign usage_o  = status_cnt_q[ADDR_DEPTH-1:0];

        // A push into an empty fall-through FIFO is visible immediately.
        assign ft_push  = FALL_THROUGH && push_i && cnt_zero;
        assign empty_o  = cnt_zero && !ft_push;
        assign data_o   = ft_push ? data_i : mem_q[read_ptr_q];

        // Fall-through push consumed in the same cycle never touches storage.
        assign pass_through = ft_push && pop_i;
        assign write_en     = push_i && !full_o  && !pass_through;
        assign read_en      = pop_i  && !empty_o && !pass_through;

        // Next-state: memory write, pointer advance with wrap, count update.
        always_comb begin : p_next
            read_ptr_d   = read_ptr_q;
            write_ptr_d  = write_ptr_q;
            status_cnt_d = status_cnt_q;
            mem_d        = mem_q;

            if (flush_i) begin
                // Flush drops everything, including a push in the same cycle.
                read_ptr_d   = '0;
                write_ptr_d  = '0;
                status_cnt_d = '0;
            end else begin
                if (write_en) begin
                    mem_d[write_ptr_q] = data_i;
                    write_ptr_d = (write_ptr_q == PTR_LAST) ? '0
                                                            : write_ptr_q + PTR_ONE;
                end

                if (read_en) begin
                    read_ptr_d = (read_ptr_q == PTR_LAST) ? '0
                                                          : read_ptr_q + PTR_ONE;
                end

                if (write_en && !read_en) begin
                    status_cnt_d = status_cnt_q + CNT_ONE;
                end else if (read_en && !write_en) begin
                    status_cnt_d = status_cnt_q - CNT_ONE;
                end
            end
        end

        // State registers; reset also clears the memory so data_o reads 0.
        always_ff @(posedge clk_i) begin : p_regs
            if (!rst_ni) begin
                read_ptr_q   <= '0;
                write_ptr_q  <= '0;
                status_cnt_q <= '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                read_ptr_q   <= read_ptr_d;
                write_ptr_q  <= write_ptr_d;
                status_cnt_q <= status_cnt_d;
                mem_q        <= mem_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Simulation-only protocol checks. A push on a full FIFO together with a
    // pop is a defined pattern (pop proceeds, push dropped) and is not flagged.
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    always @(posedge clk_i) begin : p_checks
        if (rst_ni) begin
            assert (!(push_i && full_o && !pop_i))
                else $error("trying to push new data although the FIFO is full");
            assert (!(pop_i && empty_o))
                else $error("trying to pop data although the FIFO is empty");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_v3.sv
// ----------------------------------------------------------------------------
// tb_fifo_v3
// Scoreboard bench for fifo_v3. Three instances share one expected-data queue:
//   0: DEPTH=4, FALL_THROUGH=0
//   1: DEPTH=4, FALL_THROUGH=1
//   2: DEPTH=3, FALL_THROUGH=0
// Stimulus pushes expected pop data into exp_q; the monitor pops and compares
// whenever the selected instance accepts a pop. Status outputs are checked
// directly against hand-computed values.
// ----------------------------------------------------------------------------
module tb_fifo_v3;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [2:0] push;
    logic [2:0] pop;
    logic [2:0] flush;
    logic [DW-1:0] din [3];

    wire [DW-1:0] dout  [3];
    wire [1:0]    usage [3];
    wire [2:0]    full;
    wire [2:0]    empty;

    int sel;
    int checks;
    int failures;
    logic [DW-1:0] exp_q [$];

    // DEPTH=3 interleaved sequence: push, pop, expected usage after the edge.
    bit t_push [19] = '{1,1,0,1,1,0,1,1,0,0,1,1,0,0,1,1,0,0,0};
    bit t_pop  [19] = '{0,0,1,0,0,1,1,0,1,1,0,0,1,1,0,0,1,1,1};
    int t_use  [19] = '{1,2,1,2,3,2,2,3,2,1,2,3,2,1,2,3,2,1,0};
    int fill_use [4] = '{1,2,3,0};

    always #5 clk = ~clk;

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DW), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .testmode_i(1'b0),
        .full_o(full[0]), .empty_o(empty[0]), .usage_o(usage[0]),
        .data_i(din[0]), .push_i(push[0]), .data_o(dout[0]), .pop_i(pop[0])
    );

    fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(DW), .DEPTH(4)) u_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .testmode_i(1'b0),
        .full_o(full[1]), .empty_o(empty[1]), .usage_o(usage[1]),
        .data_i(din[1]), .push_i(push[1]), .data_o(dout[1]), .pop_i(pop[1])
    );

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DW), .DEPTH(3)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]), .testmode_i(1'b0),
        .full_o(full[2]), .empty_o(empty[2]), .usage_o(usage[2]),
        .data_i(din[2]), .push_i(push[2]), .data_o(dout[2]), .pop_i(pop[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        push  = '0;
        pop   = '0;
        flush = '0;
        for (int i = 0; i < 3; i++) din[i] = '0;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input int idx,
                              input logic e_empty, input logic e_full, input int e_use);
        check($sformatf("%s_empty", tag), 32'(empty[idx]), 32'(e_empty));
        check($sformatf("%s_full",  tag), 32'(full[idx]),  32'(e_full));
        check($sformatf("%s_usage", tag), 32'(usage[idx]), 32'(e_use));
    endtask

    // Scoreboard monitor: compare head data whenever a pop is accepted.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pop[sel] === 1'b1 && empty[sel] === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: dut %0d got 0x%0h, expected no data", sel, dout[sel]);
            end else begin
                check($sformatf("pop_data_dut%0d", sel), 32'(dout[sel]), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 0;
        rst_n    = 1'b0;
        idle();
        repeat (2) step();
        rst_n = 1'b1;
        #1;

        // Reset state on every instance.
        for (int i = 0; i < 3; i++) begin
            chk_status($sformatf("reset_dut%0d", i), i, 1'b1, 1'b0, 0);
            check($sformatf("reset_dout_dut%0d", i), 32'(dout[i]), 32'h0);
        end

        // DEPTH=4: fill with A..D, usage wraps to 0 when full.
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            push[0] = 1'b1;
            din[0]  = DW'(8'hA + i);
            exp_q.push_back(DW'(8'hA + i));
            step();
            check($sformatf("fill_usage_%0d", i), 32'(usage[0]), 32'(fill_use[i]));
        end
        idle();
        #1;
        chk_status("d4_full", 0, 1'b0, 1'b1, 0);

        // Drain four entries, expect A..D then empty.
        pop[0] = 1'b1;
        repeat (4) step();
        idle();
        #1;
        chk_status("d4_drained", 0, 1'b1, 1'b0, 0);

        // Full FIFO with push+pop: head leaves, 0xE is dropped.
        for (int i = 1; i <= 4; i++) begin
            push[0] = 1'b1;
            din[0]  = DW'(i);
            exp_q.push_back(DW'(i));
            step();
        end
        push[0] = 1'b1;
        pop[0]  = 1'b1;
        din[0]  = 8'hE;
        step();
        idle();
        #1;
        chk_status("full_pushpop", 0, 1'b0, 1'b0, 3);
        pop[0] = 1'b1;
        repeat (3) step();
        idle();
        #1;
        chk_status("full_pushpop_drained", 0, 1'b1, 1'b0, 0);

        // Fall-through, push+pop on empty: passes straight through.
        sel     = 1;
        push[1] = 1'b1;
        pop[1]  = 1'b1;
        din[1]  = 8'h5;
        exp_q.push_back(8'h5);
        #1;
        check("ft_pass_dout",  32'(dout[1]),  32'h5);
        check("ft_pass_empty", 32'(empty[1]), 32'h0);
        step();
        idle();
        #1;
        chk_status("ft_pass_after", 1, 1'b1, 1'b0, 0);

        // Fall-through, push only: visible now and retained afterwards.
        push[1] = 1'b1;
        din[1]  = 8'h5;
        exp_q.push_back(8'h5);
        #1;
        check("ft_store_dout_now", 32'(dout[1]), 32'h5);
        check("ft_store_empty_now", 32'(empty[1]), 32'h0);
        step();
        push[1] = 1'b0;
        din[1]  = 8'hFF;
        #1;
        chk_status("ft_store_after", 1, 1'b0, 1'b0, 1);
        check("ft_store_dout_after", 32'(dout[1]), 32'h5);
        pop[1] = 1'b1;
        step();
        idle();
        #1;
        chk_status("ft_store_drained", 1, 1'b1, 1'b0, 0);

        // DEPTH=3 interleaved traffic: 10 elements, pointers wrap repeatedly.
        sel = 2;
        begin
            int n;
            n = 0;
            for (int r = 0; r < 19; r++) begin
                push[2] = t_push[r];
                pop[2]  = t_pop[r];
                if (t_push[r]) begin
                    din[2] = DW'(8'h30 + n);
                    exp_q.push_back(DW'(8'h30 + n));
                    n++;
                end else begin
                    din[2] = '0;
                end
                step();
                check($sformatf("d3_usage_row%0d", r), 32'(usage[2]), 32'(t_use[r]));
                check($sformatf("d3_full_row%0d", r), 32'(full[2]), 32'(t_use[r] == 3));
            end
        end
        idle();
        #1;
        check("d3_final_empty", 32'(empty[2]), 32'h1);

        // Flush with two entries and a simultaneous push.
        sel = 0;
        push[0] = 1'b1;
        din[0]  = 8'h11;
        step();
        din[0]  = 8'h22;
        step();
        flush[0] = 1'b1;
        din[0]   = 8'h33;
        step();
        idle();
        #1;
        chk_status("flush", 0, 1'b1, 1'b0, 0);
        push[0] = 1'b1;
        din[0]  = 8'h44;
        exp_q.push_back(8'h44);
        step();
        push[0] = 1'b0;
        pop[0]  = 1'b1;
        step();
        idle();
        #1;
        check("flush_reuse_empty", 32'(empty[0]), 32'h1);

        // Reset mid-operation with three entries stored.
        for (int i = 0; i < 3; i++) begin
            push[0] = 1'b1;
            din[0]  = DW'(8'h61 + i);
            step();
        end
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk_status("midreset", 0, 1'b1, 1'b0, 0);
        check("midreset_dout", 32'(dout[0]), 32'h0);
        push[0] = 1'b1;
        din[0]  = 8'h7;
        exp_q.push_back(8'h7);
        step();
        push[0] = 1'b0;
        pop[0]  = 1'b1;
        step();
        idle();
        #1;
        check("midreset_reuse_empty", 32'(empty[0]), 32'h1);

        // Every expected pop must have been observed.
        check("scoreboard_left", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
